// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Synchronises the rx pin, detects a start edge, samples
// each bit at mid-bit with a down-counting bit timer, checks parity and stop bits,
// and holds one received word for the register-bus reader.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx                  serial line (idle high, asynchronous to clk)
//   clk_div             clk cycles per bit (values < 2 behave as 2)
//   bits_per_word       number of data bits minus 1
//   parity_en           parity bit follows the data bits
//   parity_evan_odd     1: even parity, 0: odd parity
//   two_stop_bit        check two stop bits
//   rd_en               1-cycle pulse, reader consumed data_out
//   data_out            held word, zero-extended above the top data bit
//   data_ready          word waiting in data_out
//   parity_err          parity mismatch on the held word
//   frame_err           a stop bit of the held word sampled low
//   overrun             a word completed while data_ready=1 and was dropped
//   busy                receiver is inside a frame
module uart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [15:0] clk_div,
    input  logic [4:0]  bits_per_word,
    input  logic        parity_en,
    input  logic        parity_evan_odd,
    input  logic        two_stop_bit,
    input  logic        rd_en,
    output logic [15:0] data_out,
    output logic        data_ready,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CW-1:0]          cnt_q;
    logic [PW-1:0]          bit_pos_q;
    logic [DW-1:0]          shreg_q;
    logic                   acc_q;
    logic                   p_bad_q;
    logic                   f_bad_q;
    logic [DW-1:0]          data_out_q;
    logic                   data_ready_q;
    logic                   parity_err_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   busy_q;

    logic          line_c;
    logic          start_c;
    logic          tick_c;
    logic          complete_c;
    logic          f_fin_c;
    logic [CW-1:0] div_eff_c;

    // Sample point, start edge and final frame-error decision
    always_comb begin
        line_c     = sync_q[SYNC_STAGES-1];
        start_c    = prev_q & ~line_c;
        div_eff_c  = (clk_div < CW'(2)) ? CW'(2) : clk_div;
        tick_c     = (state_q != IDLE) && (cnt_q == CW'(1));
        f_fin_c    = (state_q == STOP2) ? (f_bad_q | ~line_c) : ~line_c;
        complete_c = tick_c && (((state_q == STOP) && !two_stop_bit) || (state_q == STOP2));
    end

    // Synchroniser, bit timer, frame FSM and the held-word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            bit_pos_q    <= '0;
            shreg_q      <= '0;
            acc_q        <= 1'b0;
            p_bad_q      <= 1'b0;
            f_bad_q      <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            prev_q <= line_c;

            if (state_q != IDLE) begin
                cnt_q <= tick_c ? div_eff_c : cnt_q - CW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_q   <= START;
                        busy_q    <= 1'b1;
                        bit_pos_q <= '0;
                        shreg_q   <= '0;
                        cnt_q     <= div_eff_c >> 1;
                    end
                end
                START: begin
                    if (tick_c) begin
                        // A start bit that is high again at mid-bit was a glitch
                        if (line_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                        acc_q   <= ~parity_evan_odd;
                        p_bad_q <= 1'b0;
                        f_bad_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (tick_c) begin
                        shreg_q[bit_pos_q[3:0]] <= line_c;
                        acc_q                   <= acc_q ^ line_c;
                        if (bit_pos_q == bits_per_word) begin
                            state_q <= parity_en ? PARITY : STOP;
                        end else begin
                            bit_pos_q <= bit_pos_q + PW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick_c) begin
                        p_bad_q <= (line_c != acc_q);
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick_c) begin
                        f_bad_q <= ~line_c;
                        if (two_stop_bit) begin
                            state_q <= STOP2;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                STOP2: begin
                    if (tick_c) begin
                        f_bad_q <= f_fin_c;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A completing word wins over a plain read; a read frees the holding slot
            if (complete_c) begin
                if (!data_ready_q || rd_en) begin
                    data_out_q   <= shreg_q;
                    data_ready_q <= 1'b1;
                    parity_err_q <= p_bad_q;
                    frame_err_q  <= f_fin_c;
                    overrun_q    <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rd_en && data_ready_q) begin
                data_ready_q <= 1'b0;
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_ready = data_ready_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are serialised by the bench,
// expected words are queued when a frame is sent and compared when data_ready rises.
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] clk_div;
    logic [4:0]  bits_per_word;
    logic        parity_en;
    logic        parity_evan_odd;
    logic        two_stop_bit;
    logic        rd_en;
    logic [15:0] data_out;
    logic        data_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    typedef struct {
        logic [15:0] d;
        logic        pe;
        logic        fe;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx              (rx),
        .clk_div         (clk_div),
        .bits_per_word   (bits_per_word),
        .parity_en       (parity_en),
        .parity_evan_odd (parity_evan_odd),
        .two_stop_bit    (two_stop_bit),
        .rd_en           (rd_en),
        .data_out        (data_out),
        .data_ready      (data_ready),
        .parity_err      (parity_err),
        .frame_err       (frame_err),
        .overrun         (overrun),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Correct parity bit for the low nb+1 bits of d
    function automatic logic par_bit(input logic [15:0] d, input int nb, input logic even);
        logic x;
        x = 1'b0;
        for (int i = 0; i <= nb; i++) x = x ^ d[i];
        return even ? x : ~x;
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    // Serialise one frame at negedges; optional rd_en pulse at cycle rd_at; reports
    // the first cycle at which busy was seen low again
    task automatic send_frame(input logic [15:0] d, input logic pbit, input logic stopv,
                              input int rd_at, output int fall_at);
        logic [19:0] bits;
        int          n;
        int          div;
        int          cyc;
        logic        was_busy;
        div  = (clk_div < 16'd2) ? 2 : int'(clk_div);
        bits = '0;
        n    = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i <= int'(bits_per_word); i++) begin bits[n] = d[i]; n++; end
        if (parity_en) begin bits[n] = pbit; n++; end
        bits[n] = stopv; n++;
        if (two_stop_bit) begin bits[n] = stopv; n++; end
        cyc      = 0;
        fall_at  = -1;
        was_busy = busy;
        for (int b = 0; b < n; b++) begin
            rx = bits[b];
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                cyc++;
                rd_en = (cyc == rd_at);
                if (was_busy && !busy && fall_at < 0) fall_at = cyc;
                was_busy = busy;
            end
        end
        rx    = 1'b1;
        rd_en = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (data_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_rd();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0;
        clk_div = 16'd16; bits_per_word = 5'd7; parity_en = 1'b0;
        parity_evan_odd = 1'b1; two_stop_bit = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({data_out, data_ready, parity_err, frame_err, overrun, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_in: got %h expected 0",
                     {data_out, data_ready, parity_err, frame_err, overrun, busy});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++;
        if ({data_out, data_ready, parity_err, frame_err, overrun, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected 0",
                     {data_out, data_ready, parity_err, frame_err, overrun, busy});
        end
    endtask

    task automatic test_basic();
        exp_t e; bit ok; int f;
        clk_div = 16'd16; bits_per_word = 5'd7; parity_en = 1'b0; two_stop_bit = 1'b0;
        sb.push_back(mk_exp(16'h00A5, 1'b0, 1'b0));
        send_frame(16'h00A5, 1'b0, 1'b1, -1, f);
        wait_ready(ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {data_out, parity_err, frame_err, overrun} !== {e.d, e.pe, e.fe, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_word: got ok=%0b %h pe=%b fe=%b ov=%b expected %h pe=%b fe=%b ov=0",
                     ok, data_out, parity_err, frame_err, overrun, e.d, e.pe, e.fe);
        end
        pulse_rd();
        n_tests++;
        if (data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rd: data_ready got %b expected 0", data_ready);
        end
    endtask

    task automatic test_parity();
        exp_t e; bit ok; int f;
        logic [1:0] pb;
        pb = 2'b01;
        bits_per_word = 5'd7; parity_en = 1'b1; parity_evan_odd = 1'b1; two_stop_bit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk_exp(16'h0003, pb[k] != par_bit(16'h0003, 7, 1'b1), 1'b0));
            send_frame(16'h0003, pb[k], 1'b1, -1, f);
            wait_ready(ok);
            e = sb.pop_front();
            n_tests++;
            if (!ok || {data_out, parity_err, frame_err} !== {e.d, e.pe, e.fe}) begin
                n_fail++;
                $display("FAIL parity_%0d: got ok=%0b %h pe=%b fe=%b expected %h pe=%b fe=%b",
                         k, ok, data_out, parity_err, frame_err, e.d, e.pe, e.fe);
            end
            pulse_rd();
        end
    endtask

    task automatic test_min_div();
        exp_t e; bit ok; int f;
        clk_div = 16'd1; bits_per_word = 5'd7; parity_en = 1'b1; parity_evan_odd = 1'b0;
        sb.push_back(mk_exp(16'h005C, 1'b0, 1'b0));
        send_frame(16'h005C, par_bit(16'h005C, 7, 1'b0), 1'b1, -1, f);
        wait_ready(ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {data_out, parity_err, frame_err} !== {e.d, e.pe, e.fe}) begin
            n_fail++;
            $display("FAIL min_div: got ok=%0b %h pe=%b fe=%b expected %h pe=%b fe=%b",
                     ok, data_out, parity_err, frame_err, e.d, e.pe, e.fe);
        end
        pulse_rd();
        clk_div = 16'd16; parity_en = 1'b0; parity_evan_odd = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_frame_break();
        exp_t e; bit ok; int f;
        sb.push_back(mk_exp(16'h005A, 1'b0, 1'b1));
        send_frame(16'h005A, 1'b0, 1'b0, -1, f);
        wait_ready(ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {data_out, parity_err, frame_err} !== {e.d, e.pe, e.fe}) begin
            n_fail++;
            $display("FAIL stop_low: got ok=%0b %h pe=%b fe=%b expected %h pe=%b fe=%b",
                     ok, data_out, parity_err, frame_err, e.d, e.pe, e.fe);
        end
        pulse_rd();
        repeat (32) @(negedge clk);
        sb.push_back(mk_exp(16'h0000, 1'b0, 1'b1));
        rx = 1'b0;
        repeat (40 * 16) @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if ({data_ready, data_out, parity_err, frame_err, overrun} !== {1'b1, e.d, e.pe, e.fe, 1'b0}) begin
            n_fail++;
            $display("FAIL break_word: got dr=%b %h pe=%b fe=%b ov=%b expected dr=1 %h pe=%b fe=%b ov=0",
                     data_ready, data_out, parity_err, frame_err, overrun, e.d, e.pe, e.fe);
        end
        rx = 1'b1;
        repeat (64) @(negedge clk);
        n_tests++;
        if ({data_ready, overrun, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL break_release: got dr=%b ov=%b busy=%b expected dr=1 ov=0 busy=0",
                     data_ready, overrun, busy);
        end
        pulse_rd();
    endtask

    task automatic test_glitch();
        logic saw_busy;
        saw_busy = 1'b0;
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        n_tests++;
        if ({saw_busy, busy, data_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL glitch: got saw_busy=%b busy=%b dr=%b expected 1 0 0",
                     saw_busy, busy, data_ready);
        end
    endtask

    task automatic test_overrun();
        exp_t e; bit ok; int f; int fall;
        sb.push_back(mk_exp(16'h0011, 1'b0, 1'b0));
        send_frame(16'h0011, 1'b0, 1'b1, -1, f);
        wait_ready(ok);
        send_frame(16'h0022, 1'b0, 1'b1, -1, fall);
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {data_ready, data_out, overrun} !== {1'b1, e.d, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_set: got ok=%0b dr=%b %h ov=%b expected dr=1 %h ov=1",
                     ok, data_ready, data_out, overrun, e.d);
        end
        pulse_rd();
        n_tests++;
        if ({data_ready, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL overrun_clr: got dr=%b ov=%b expected 0 0", data_ready, overrun);
        end
        sb.push_back(mk_exp(16'h0011, 1'b0, 1'b0));
        send_frame(16'h0011, 1'b0, 1'b1, -1, f);
        wait_ready(ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || data_out !== e.d || fall < 2) begin
            n_fail++;
            $display("FAIL overrun_pre: got ok=%0b %h fall=%0d expected %h fall>=2",
                     ok, data_out, fall, e.d);
        end
        sb.push_back(mk_exp(16'h0022, 1'b0, 1'b0));
        send_frame(16'h0022, 1'b0, 1'b1, fall - 1, f);
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        n_tests++;
        if ({data_ready, data_out, overrun} !== {1'b1, e.d, 1'b0}) begin
            n_fail++;
            $display("FAIL overrun_rd_same: got dr=%b %h ov=%b expected dr=1 %h ov=0",
                     data_ready, data_out, overrun, e.d);
        end
        pulse_rd();
    endtask

    task automatic test_wide_reset();
        exp_t e; bit ok; int f;
        clk_div = 16'd16; bits_per_word = 5'd15; parity_en = 1'b0; two_stop_bit = 1'b1;
        sb.push_back(mk_exp(16'hBEEF, 1'b0, 1'b0));
        send_frame(16'hBEEF, 1'b0, 1'b1, -1, f);
        wait_ready(ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {data_out, parity_err, frame_err} !== {e.d, e.pe, e.fe}) begin
            n_fail++;
            $display("FAIL wide_word: got ok=%0b %h pe=%b fe=%b expected %h pe=%b fe=%b",
                     ok, data_out, parity_err, frame_err, e.d, e.pe, e.fe);
        end
        repeat (20) @(negedge clk);
        rx = 1'b0;
        repeat (16 * 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({data_out, data_ready, parity_err, frame_err, overrun, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 0",
                     {data_out, data_ready, parity_err, frame_err, overrun, busy});
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        sb.push_back(mk_exp(16'h1234, 1'b0, 1'b0));
        send_frame(16'h1234, 1'b0, 1'b1, -1, f);
        wait_ready(ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || {data_out, parity_err, frame_err, overrun} !== {e.d, e.pe, e.fe, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset: got ok=%0b %h pe=%b fe=%b ov=%b expected %h pe=%b fe=%b ov=0",
                     ok, data_out, parity_err, frame_err, overrun, e.d, e.pe, e.fe);
        end
        pulse_rd();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_min_div();
        test_frame_break();
        test_glitch();
        test_overrun();
        test_wide_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
